// File: rtl/mini_micro_pkg.sv
// Shared widths, opcode constants and fetch FSM state type for the mini micro core.
package mini_micro_pkg;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned OPCODE_SIZE = 5;
  localparam int unsigned ADDR_SIZE   = 8;

  localparam logic [4:0] OPC_NOP  = 5'b00000;
  localparam logic [4:0] OPC_ADD  = 5'b00110;
  localparam logic [4:0] OPC_LOAD = 5'b10011;
  localparam logic [4:0] OPC_HALT = 5'b11111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load-target has priority over increment; arithmetic wraps modulo 2^Width.
module pc_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] target_i,
  input  logic             incr_i,
  output logic [Width-1:0] pc_o
);

  logic [Width-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (incr_i) begin
      pc_d = pc_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue unit with single-outstanding memory handshake and branch redirect.
// Define FETCH_HALT_DETECT_EN to stop fetching after a consumed HALT opcode.
module fetch_unit
  import mini_micro_pkg::*;
#(
  parameter int unsigned word_size   = WORD_SIZE,
  parameter int unsigned opcode_size = OPCODE_SIZE,
  parameter int unsigned addr_size   = ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [addr_size-1:0] imem_addr,
  input  logic                 imem_rvalid,
  input  logic [word_size-1:0] imem_rdata,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [addr_size-1:0] branch_target,
  output logic [word_size-1:0] instruction,
  output logic                 instr_valid,
  output logic [addr_size-1:0] pc,
  output logic                 halted
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltDetectEn = 1'b1;
`else
  localparam bit HaltDetectEn = 1'b0;
`endif

  localparam logic [opcode_size-1:0] OpcHalt = opcode_size'(OPC_HALT);

  fetch_state_t         state_d, state_q;
  logic                 discard_d, discard_q;
  logic [word_size-1:0] instr_d, instr_q;
  logic                 valid_d, valid_q;
  logic                 halted_d, halted_q;
  logic                 pc_load, pc_incr;
  logic                 is_halt_op;

  assign is_halt_op = (instr_q[word_size-1 -: opcode_size] == OpcHalt);

  pc_reg #(
    .Width(addr_size)
  ) u_pc_reg (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (pc_load),
    .target_i(branch_target),
    .incr_i  (pc_incr),
    .pc_o    (pc)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    pc_load   = 1'b0;
    pc_incr   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          instr_d = '0;
          // A response arriving with the redirect closes the old request.
          discard_d = !imem_rvalid;
        end else if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            pc_incr = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          instr_d = '0;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          if (HaltDetectEn && is_halt_op) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        if (branch_taken) begin
          pc_load  = 1'b1;
          instr_d  = '0;
          halted_d = 1'b0;
          state_d  = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      discard_q <= 1'b0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit; define FETCH_HALT_DETECT_EN to exercise the HALT state.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .halted       (halted)
  );

  function automatic exp_t pop_exp();
    exp_t e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
    if (imem_req !== 1'b1) begin
      checks++;
      errors++;
      ok = 1'b0;
      $display("FAIL req_timeout: imem_req=%b after 20 cycles, want 1", imem_req);
    end
  endtask

  // Serve the pending request one cycle after it is seen; optionally redirect on the same edge.
  task automatic fetch_word(input logic [31:0] data, input bit live, input bit br,
                            input logic [7:0] tgt);
    bit ok;
    logic [7:0] a;
    wait_req(ok);
    if (!ok) return;
    a = imem_addr;
    @(negedge clk);
    imem_rvalid   = 1'b1;
    imem_rdata    = data;
    branch_taken  = br;
    branch_target = tgt;
    if (live) sb.push_back('{word: data, pc: a + 8'd1});
    @(negedge clk);
    imem_rvalid  = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (instruction !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_instr: instr=%h valid=%b, want 0/0", instruction, instr_valid);
    end
    checks++;
    if (imem_req !== 1'b0 || pc !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%b pc=%h halted=%b, want 0/00/0", imem_req, pc, halted);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: req=%b, want 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_first_req: req=%b addr=%h valid=%b, want 1/00/0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_load_issue();
    exp_t e;
    fetch_word(32'h9800_0000, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL load_issue: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_next_req: req=%b addr=%h valid=%b, want 1/01/0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    fetch_word(32'h3000_0202, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL add_issue: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 32'h3000_0202 || pc !== 8'h02 ||
          imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h req=%b, want 1/30000202/02/0",
                 i, instr_valid, instruction, pc, imem_req);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h02 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b, want 1/02/0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    fetch_word(32'h0000_0001, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL pre_redirect_issue: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (pc !== 8'h40 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect_outstanding: pc=%h valid=%b req=%b, want 40/0/1",
               pc, instr_valid, imem_req);
    end
    fetch_word(32'hDEAD_BEEF, 1'b0, 1'b0, 8'h00);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL redirect_drop: valid=%b req=%b addr=%h, want 0/1/40",
               instr_valid, imem_req, imem_addr);
    end
    fetch_word(32'h3000_0040, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL redirect_target_issue: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
  endtask

  task automatic test_wrap_simultaneous();
    exp_t e;
    @(negedge clk);
    fetch_word(32'h0000_0041, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL issue_41: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'hFF;
    @(negedge clk);
    stall        = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc !== 8'hFF || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect_over_stall: valid=%b instr=%h pc=%h req=%b, want 0/0/FF/1",
               instr_valid, instruction, pc, imem_req);
    end
    fetch_word(32'h9800_0010, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== 8'h00 || e.pc !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap: valid=%b instr=%h pc=%h, want 1/%h/00",
               instr_valid, instruction, pc, e.word);
    end
    @(negedge clk);
    fetch_word(32'h1111_1111, 1'b0, 1'b1, 8'h20);
    checks++;
    if (instr_valid !== 1'b0 || pc !== 8'h20 || imem_req !== 1'b1 || imem_addr !== 8'h20) begin
      errors++;
      $display("FAIL branch_with_rvalid: valid=%b pc=%h req=%b addr=%h, want 0/20/1/20",
               instr_valid, pc, imem_req, imem_addr);
    end
    fetch_word(32'h3000_0020, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL no_stale_discard: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    @(negedge clk);
    fetch_word(32'hF800_0000, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL halt_word_issue: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
    @(negedge clk);
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 8'h22) begin
        errors++;
        $display("FAIL halt_hold[%0d]: halted=%b req=%b valid=%b pc=%h, want 1/0/0/22",
                 i, halted, imem_req, instr_valid, pc);
      end
      @(negedge clk);
    end
    branch_taken  = 1'b1;
    branch_target = 8'h10;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL halt_exit: halted=%b req=%b addr=%h, want 0/1/10",
               halted, imem_req, imem_addr);
    end
`else
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h22) begin
      errors++;
      $display("FAIL halt_disabled: halted=%b req=%b addr=%h, want 0/1/22",
               halted, imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      r[31] = 1'b0;
      fetch_word(r, 1'b1, 1'b0, 8'h00);
      e = pop_exp();
      checks++;
      if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b instr=%h pc=%h, want 1/%h/%h",
                 i, instr_valid, instruction, pc, e.word, e.pc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_fetch();
    exp_t e;
    fetch_word(32'h9800_0000, 1'b1, 1'b0, 8'h00);
    e = pop_exp();
    checks++;
    if (instr_valid !== 1'b1 || instruction !== e.word || pc !== e.pc) begin
      errors++;
      $display("FAIL pre_reset_issue: valid=%b instr=%h pc=%h, want 1/%h/%h",
               instr_valid, instruction, pc, e.word, e.pc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instruction !== 32'h0 || pc !== 8'h00 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b instr=%h pc=%h req=%b, want 0/0/00/0",
               instr_valid, instruction, pc, imem_req);
    end
    @(negedge clk);
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instruction !== 32'h0 || imem_req !== 1'b1 ||
        imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL late_rvalid_boot: valid=%b instr=%h req=%b addr=%h, want 0/0/1/00",
               instr_valid, instruction, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid_after: valid=%b, want 0", instr_valid);
    end
  endtask

  initial begin
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    test_reset();
    test_load_issue();
    test_stall();
    test_redirect();
    test_wrap_simultaneous();
    test_halt();
    test_back_to_back();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch/issue unit; the producer end of the instruction interface consumed by Control_Unit.
- Holds the PC and requests words from instruction memory over a single-outstanding req/rvalid handshake.
- Presents each fetched word on `instruction` with a valid flag; holds it while the decoder stalls.
- Accepts branch redirects from execute and discards in-flight fetches on redirect.

Parameters:
word_size, 32, instruction/data word width
opcode_size, 5, opcode field width (instruction[word_size-1 -: opcode_size])
addr_size, 8, word-addressed instruction memory address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  output  1  fetch request, held until imem_rvalid
imem_addr  output  addr_size  fetch address; equals pc, stable while imem_req=1
imem_rvalid  input  1  one-cycle pulse, response data valid; never in same cycle req first rises
imem_rdata  input  word_size  fetched word, sampled when imem_rvalid=1
stall  input  1  decoder not ready; held instruction must not advance
branch_taken  input  1  one-cycle redirect pulse
branch_target  input  addr_size  new pc, sampled with branch_taken
instruction  output  word_size  instruction to Control_Unit
instr_valid  output  1  instruction holds a live word
pc  output  addr_size  address of next fetch
halted  output  1  HALT reached (see Optional Feature)

Behaviour:
- Reset (rst=0, async): pc=0, instruction=0 (NOP), instr_valid=0, imem_req=0, halted=0, discard=0, state=BOOT.
- States: BOOT, FETCH, ISSUE, HALT.
- BOOT: one cycle after rst deasserts -> FETCH. imem_rvalid in BOOT is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_rvalid with discard=0: instruction<=imem_rdata, instr_valid<=1, pc<=pc+1 -> ISSUE.
  - On imem_rvalid with discard=1: drop data, clear discard, stay FETCH; new request the next cycle at the redirected pc.
- ISSUE:
  - imem_req=0, instr_valid=1.
  - stall=0: word consumed at this edge; instr_valid<=0 -> FETCH.
  - stall=1: instruction, instr_valid and pc are held unchanged.
- Throughput: with 1-cycle memory, one instruction per 3 cycles (req, rvalid, issue).
- Redirect (branch_taken=1, any state except BOOT):
  - pc<=branch_target; instr_valid<=0; instruction<=0.
  - In FETCH with a request outstanding: set discard=1, keep imem_req until rvalid.
  - In ISSUE: held word dropped -> FETCH.
  - branch_taken together with imem_rvalid (discard=0): redirect wins; data dropped, discard not set -> FETCH at target.
  - Simultaneous branch_taken and stall=1 in ISSUE: redirect wins.
- pc arithmetic is modulo 2^addr_size: 8'hFF + 1 wraps to 8'h00.
- stall is ignored while instr_valid=0.
- Reset mid-fetch: everything clears asynchronously. A late imem_rvalid after reset falls in BOOT and is ignored.

Optional Feature:
FETCH_HALT_DETECT_EN
- Defined:
  - In ISSUE, a consumed word whose opcode equals OPC_HALT (5'b11111) moves the unit to HALT.
  - HALT: imem_req=0, instr_valid=0, halted=1, pc held.
  - Exit only via branch_taken (-> FETCH, halted<=0) or reset.
- Undefined: opcode 5'b11111 is issued like any other word, and halted is tied 0.

Decomposition:
- Package mini_micro_pkg:
  - word_size/opcode_size/addr_size defaults.
  - Opcode constants OPC_NOP=5'b00000, OPC_ADD=5'b00110, OPC_LOAD=5'b10011, OPC_HALT=5'b11111.
  - Enum fetch_state_t {BOOT, FETCH, ISSUE, HALT}.
- One sub-module, pc_reg: async active-low reset, load-target / increment / hold control, modulo wrap.

Test Plan:
1. Reset then boot: rst=0 for 10 ns, release -> one BOOT cycle; next cycle imem_req=1, imem_addr=0; instruction=0, instr_valid=0 throughout reset.
2. LOAD issue: memory returns 32'b10011000...0 one cycle after req -> next cycle instruction=0x98000000, instr_valid=1, pc=1; stall=0 -> next req at addr 1.
3. Stall hold: ADD word 0x30000202 issued with stall=1 for 4 cycles -> instruction, instr_valid=1 and pc=2 stable; no imem_req until stall drops.
4. Redirect with outstanding fetch: branch_taken with target 8'h40 while req at addr 3 pending -> response dropped, instr_valid stays 0, next req at 8'h40.
5. Wrap/simultaneous: pc=8'hFF fetch completes -> pc=8'h00; branch_taken coincident with rvalid -> data dropped, req at target.
6. With FETCH_HALT_DETECT_EN: issue 0xF8000000, stall=0 -> halted=1, imem_req=0 for 10 cycles; branch_taken target 8'h10 -> halted=0, req at 8'h10. Without the macro, same word issued normally and halted=0.
